// File: rtl/bt_cmd_pkg.sv
// Shared types and constants for the Bluetooth command sequencer.
// Holds the FSM state encoding, the command descriptor and the fixed command tables.
package bt_cmd_pkg;

  localparam int unsigned START_W = 5;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned N_INIT  = 3;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SEND,
    INIT_RESP,
    READY,
    BTN_SEND,
    BTN_RESP,
    FAIL
  } state_t;

  typedef struct packed {
    logic [START_W-1:0] start;
    logic [LEN_W-1:0]   len;
  } cmd_t;

  localparam cmd_t CMD_INIT0 = {5'h00, 4'd6};
  localparam cmd_t CMD_INIT1 = {5'h06, 4'd10};
  localparam cmd_t CMD_INIT2 = {5'h10, 4'd5};
  localparam cmd_t CMD_NEXT  = {5'h15, 4'd4};
  localparam cmd_t CMD_PREV  = {5'h19, 4'd4};

  // Counter width for a count range of n, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic cmd_t init_cmd(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): return CMD_INIT0;
      IDX_W'(1): return CMD_INIT1;
      default:   return CMD_INIT2;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer: two-flop metastability guard plus falling-edge detect.
// Produces a one-cycle press pulse for an active-low push button.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_c_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= btn_n_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press_c_o = s3_q & ~s2_q;

endmodule

// File: rtl/bt_cmd_seq.sv
// Command sequencer for the snd_cmd engine: power-up wait, init command list,
// then next/prev track commands, each with response timeout and bounded retry.
module bt_cmd_seq
  import bt_cmd_pkg::*;
#(
  parameter int unsigned INIT_WAIT    = 131072,
  parameter int unsigned RESP_TIMEOUT = 1048576,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_n,
  input  logic               prev_n,
  input  logic               resp_rcvd,
  output logic               send,
  output logic [START_W-1:0] cmd_start,
  output logic [LEN_W-1:0]   cmd_len,
  output logic               init_done,
  output logic               busy,
  output logic               err
);

  localparam int unsigned WAIT_W = cnt_w(INIT_WAIT);
  localparam int unsigned TMO_W  = cnt_w(RESP_TIMEOUT);
  localparam int unsigned RTY_W  = cnt_w(MAX_RETRY + 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sel_q, sel_d;
  logic               nxt_q, nxt_d, prv_q, prv_d;
  logic               send_q, send_d;
  cmd_t               cmd_q, cmd_d;
  logic               init_done_q, init_done_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               nxt_press_c, prv_press_c;
  logic               tmo_hit_c, rty_left_c;

  btn_edge u_next (.clk(clk), .rst_n(rst_n), .btn_n_i(next_n), .press_c_o(nxt_press_c));
  btn_edge u_prev (.clk(clk), .rst_n(rst_n), .btn_n_i(prev_n), .press_c_o(prv_press_c));

  assign tmo_hit_c  = (tmo_q == TMO_W'(RESP_TIMEOUT - 1));
  assign rty_left_c = (rty_q < RTY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      wait_q      <= '0;
      tmo_q       <= '0;
      rty_q       <= '0;
      idx_q       <= '0;
      sel_q       <= 1'b0;
      nxt_q       <= 1'b0;
      prv_q       <= 1'b0;
      send_q      <= 1'b0;
      cmd_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      rty_q       <= rty_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      nxt_q       <= nxt_d;
      prv_q       <= prv_d;
      send_q      <= send_d;
      cmd_q       <= cmd_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    rty_d       = rty_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    nxt_d       = nxt_q;
    prv_d       = prv_q;
    send_d      = 1'b0;
    cmd_d       = cmd_q;
    init_done_d = init_done_q;
    err_d       = err_q;

    unique case (state_q)
      PWR_WAIT: begin
        if (wait_q == WAIT_W'(INIT_WAIT - 1)) begin
          idx_d   = '0;
          state_d = INIT_SEND;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      INIT_SEND: begin
        send_d  = 1'b1;
        cmd_d   = init_cmd(idx_q);
        tmo_d   = '0;
        state_d = INIT_RESP;
      end
      // A response in the timeout cycle takes precedence over a retry
      INIT_RESP: begin
        if (resp_rcvd) begin
          rty_d = '0;
          if (idx_q == IDX_W'(N_INIT - 1)) begin
            init_done_d = 1'b1;
            state_d     = READY;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = INIT_SEND;
          end
        end else if (tmo_hit_c) begin
          if (rty_left_c) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = INIT_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = FAIL;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      READY: begin
        if (nxt_q) begin
          nxt_d   = 1'b0;
          sel_d   = 1'b0;
          state_d = BTN_SEND;
        end else if (prv_q) begin
          prv_d   = 1'b0;
          sel_d   = 1'b1;
          state_d = BTN_SEND;
        end
      end
      BTN_SEND: begin
        send_d  = 1'b1;
        cmd_d   = sel_q ? CMD_PREV : CMD_NEXT;
        tmo_d   = '0;
        state_d = BTN_RESP;
      end
      BTN_RESP: begin
        if (resp_rcvd) begin
          rty_d   = '0;
          state_d = READY;
        end else if (tmo_hit_c) begin
          if (rty_left_c) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = BTN_SEND;
          end else begin
            rty_d   = '0;
            err_d   = 1'b1;
            state_d = READY;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FAIL: ;
      default: state_d = PWR_WAIT;
    endcase

    // A new press overrides the clear issued by READY in the same cycle
    if (nxt_press_c) nxt_d = 1'b1;
    if (prv_press_c) prv_d = 1'b1;

    busy_d = (state_d != READY) && (state_d != FAIL);
  end

  assign send      = send_q;
  assign cmd_start = cmd_q.start;
  assign cmd_len   = cmd_q.len;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bt_cmd_seq.sv
// Directed bench for bt_cmd_seq with short timing parameters: init timeline table
// plus hand sequences for buttons, retries, FAIL, mid-run reset and resp/timeout collision.
module tb_bt_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       next_n;
  logic       prev_n;
  logic       resp_rcvd;
  logic       send;
  logic [4:0] cmd_start;
  logic [3:0] cmd_len;
  logic       init_done;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int send_cnt = 0;

  bt_cmd_seq #(.INIT_WAIT(16), .RESP_TIMEOUT(32), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .next_n(next_n), .prev_n(prev_n),
    .resp_rcvd(resp_rcvd), .send(send), .cmd_start(cmd_start),
    .cmd_len(cmd_len), .init_done(init_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (send) send_cnt <= send_cnt + 1;

  typedef struct {
    int unsigned adv;
    logic        resp;
    logic        send;
    logic [4:0]  st;
    logic [3:0]  ln;
    logic        busy;
    logic        idn;
    logic        err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_resp();
    resp_rcvd = 1'b1;
    nx();
    resp_rcvd = 1'b0;
  endtask

  task automatic wait_send(input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      nx();
      if (send) begin
        at = cyc;
        break;
      end
    end
    chk("send_seen", 32'(at != -1), 32'd1);
  endtask

  task automatic chk_cmd(input string nm, input logic [4:0] st, input logic [3:0] ln);
    chk({nm, "_start"}, 32'(cmd_start), 32'(st));
    chk({nm, "_len"}, 32'(cmd_len), 32'(ln));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_send"}, 32'(send), 32'd0);
    chk({nm, "_start"}, 32'(cmd_start), 32'd0);
    chk({nm, "_len"}, 32'(cmd_len), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_init_done"}, 32'(init_done), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, n0, t1, t2, t3, t;

    // adv, resp, send, start, len, busy, init_done, err
    tbl[0]  = '{16, 1'b0, 1'b0, 5'h00, 4'd0,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b0, 1'b1, 5'h00, 4'd6,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{5,  1'b0, 1'b0, 5'h00, 4'd6,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1,  1'b1, 1'b0, 5'h00, 4'd6,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1,  1'b0, 1'b1, 5'h06, 4'd10, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{5,  1'b0, 1'b0, 5'h06, 4'd10, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1,  1'b1, 1'b0, 5'h06, 4'd10, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1,  1'b0, 1'b1, 5'h10, 4'd5,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{5,  1'b0, 1'b0, 5'h10, 4'd5,  1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1,  1'b1, 1'b0, 5'h10, 4'd5,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{3,  1'b1, 1'b0, 5'h10, 4'd5,  1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; next_n = 1'b1; prev_n = 1'b1; resp_rcvd = 1'b0;
    repeat (3) nx();
    chk_reset_vals("por");

    // Scenario 1: init timeline, responses 5 cycles after each send
    rst_n = 1'b1;
    n0 = send_cnt;
    for (int i = 0; i < 11; i++) begin
      resp_rcvd = tbl[i].resp;
      nx();
      resp_rcvd = 1'b0;
      repeat (tbl[i].adv - 1) nx();
      chk($sformatf("tbl%0d_send", i), 32'(send), 32'(tbl[i].send));
      chk($sformatf("tbl%0d_start", i), 32'(cmd_start), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_len", i), 32'(cmd_len), 32'(tbl[i].ln));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_init_done", i), 32'(init_done), 32'(tbl[i].idn));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
    end
    chk("init_send_count", 32'(send_cnt - n0), 32'd3);

    // Scenario 2: long next press yields exactly one NEXT command
    n0 = send_cnt;
    next_n = 1'b0;
    wait_send(12, t);
    chk_cmd("s2_next", 5'h15, 4'd4);
    repeat (5) nx();
    next_n = 1'b1;
    chk("s2_busy_wait", 32'(busy), 32'd1);
    pulse_resp();
    chk("s2_busy_done", 32'(busy), 32'd0);
    repeat (20) nx();
    chk("s2_send_count", 32'(send_cnt - n0), 32'd1);

    // Scenario 3: simultaneous presses, NEXT first then PREV
    n0 = send_cnt;
    next_n = 1'b0; prev_n = 1'b0;
    wait_send(12, t);
    chk_cmd("s3_first", 5'h15, 4'd4);
    repeat (2) nx();
    next_n = 1'b1; prev_n = 1'b1;
    pulse_resp();
    wait_send(12, t);
    chk_cmd("s3_second", 5'h19, 4'd4);
    pulse_resp();
    repeat (40) nx();
    chk("s3_send_count", 32'(send_cnt - n0), 32'd2);
    chk("s3_busy", 32'(busy), 32'd0);

    // Scenario 5: button command never answered
    n0 = send_cnt;
    prev_n = 1'b0;
    repeat (3) nx();
    prev_n = 1'b1;
    wait_send(12, t1);
    chk_cmd("s5_try0", 5'h19, 4'd4);
    wait_send(40, t2);
    chk("s5_gap1", 32'(t2 - t1), 32'd33);
    chk_cmd("s5_try1", 5'h19, 4'd4);
    wait_send(40, t3);
    chk("s5_gap2", 32'(t3 - t2), 32'd33);
    chk_cmd("s5_try2", 5'h19, 4'd4);
    repeat (31) nx();
    chk("s5_err_before", 32'(err), 32'd0);
    chk("s5_busy_before", 32'(busy), 32'd1);
    nx();
    chk("s5_err", 32'(err), 32'd1);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_init_done", 32'(init_done), 32'd1);
    repeat (10) nx();
    chk("s5_send_count", 32'(send_cnt - n0), 32'd3);
    next_n = 1'b0;
    repeat (3) nx();
    next_n = 1'b1;
    wait_send(12, t);
    chk_cmd("s5_after", 5'h15, 4'd4);
    pulse_resp();
    chk("s5_err_sticky", 32'(err), 32'd1);

    // Scenario 4: init command 0 never answered -> FAIL
    rst_n = 1'b0;
    nx();
    chk_reset_vals("s4_rst");
    rst_n = 1'b1;
    rel = cyc;
    n0 = send_cnt;
    nx();
    pulse_resp();
    wait_send(30, t1);
    chk("s4_first_lat", 32'(t1 - rel), 32'd17);
    chk_cmd("s4_try0", 5'h00, 4'd6);
    wait_send(40, t2);
    chk("s4_gap1", 32'(t2 - t1), 32'd33);
    chk_cmd("s4_try1", 5'h00, 4'd6);
    wait_send(40, t3);
    chk("s4_gap2", 32'(t3 - t2), 32'd33);
    chk_cmd("s4_try2", 5'h00, 4'd6);
    repeat (31) nx();
    chk("s4_err_before", 32'(err), 32'd0);
    nx();
    chk("s4_err", 32'(err), 32'd1);
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_init_done", 32'(init_done), 32'd0);
    next_n = 1'b0;
    repeat (3) nx();
    next_n = 1'b1;
    repeat (60) nx();
    chk("s4_send_count", 32'(send_cnt - n0), 32'd3);
    chk("s4_busy_hold", 32'(busy), 32'd0);

    // Scenario 6: reset during INIT_RESP of command 1, then resp/timeout collision
    rst_n = 1'b0;
    nx();
    rst_n = 1'b1;
    wait_send(30, t);
    repeat (3) nx();
    pulse_resp();
    wait_send(10, t);
    chk_cmd("s6_cmd1", 5'h06, 4'd10);
    repeat (4) nx();
    rst_n = 1'b0;
    #2;
    chk_reset_vals("s6_async");
    nx();
    rst_n = 1'b1;
    rel = cyc;
    wait_send(30, t1);
    chk("s6_first_lat", 32'(t1 - rel), 32'd17);
    chk_cmd("s6_restart", 5'h00, 4'd6);
    repeat (31) nx();
    pulse_resp();
    wait_send(5, t2);
    chk("s6_collide_gap", 32'(t2 - t1), 32'd33);
    chk_cmd("s6_collide", 5'h06, 4'd10);
    pulse_resp();
    wait_send(5, t);
    chk_cmd("s6_cmd2", 5'h10, 4'd5);
    pulse_resp();
    chk("s6_init_done", 32'(init_done), 32'd1);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
